// File: rtl/cmult_share_arb_if.sv
// ---------------------------------------------------------------------------
// cmult_share_arb_if
//   Bundle of every bus the arbiter touches: the requester side (req,
//   packed operand buses, gnt, result strobe/data) and the multiplier side
//   (operands out, product in).
//
//   modport slave  : the arbiter's view (cmult_share_arb)
//   modport master : the environment's view (requesters + multiplier)
//
//   Parameters must match the ones given to cmult_share_arb.
// ---------------------------------------------------------------------------
interface cmult_share_arb_if #(
    parameter int N_REQ   = 3,
    parameter int D1_SIZE = 13,
    parameter int D2_SIZE = 11
);
    // requester side
    logic [N_REQ-1:0]         req;
    logic [N_REQ*D1_SIZE-1:0] d1_re_bus;
    logic [N_REQ*D1_SIZE-1:0] d1_im_bus;
    logic [N_REQ*D2_SIZE-1:0] d2_re_bus;
    logic [N_REQ*D2_SIZE-1:0] d2_im_bus;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rsp_vld;
    logic [D1_SIZE:0]         rsp_re;
    logic [D1_SIZE:0]         rsp_im;

    // multiplier side
    logic                     m_di_vld;
    logic [D1_SIZE-1:0]       m_d1_re;
    logic [D1_SIZE-1:0]       m_d1_im;
    logic [D2_SIZE-1:0]       m_d2_re;
    logic [D2_SIZE-1:0]       m_d2_im;
    logic                     m_do_vld;
    logic [D1_SIZE:0]         m_do_re;
    logic [D1_SIZE:0]         m_do_im;

    modport slave (
        input  req, d1_re_bus, d1_im_bus, d2_re_bus, d2_im_bus,
        input  m_do_vld, m_do_re, m_do_im,
        output gnt, rsp_vld, rsp_re, rsp_im,
        output m_di_vld, m_d1_re, m_d1_im, m_d2_re, m_d2_im
    );

    modport master (
        output req, d1_re_bus, d1_im_bus, d2_re_bus, d2_im_bus,
        output m_do_vld, m_do_re, m_do_im,
        input  gnt, rsp_vld, rsp_re, rsp_im,
        input  m_di_vld, m_d1_re, m_d1_im, m_d2_re, m_d2_im
    );
endinterface

// File: rtl/cmult_share_arb.sv
// ---------------------------------------------------------------------------
// cmult_share_arb
//   Round-robin arbiter that time-shares one external complex multiplier
//   (MULT_LAT-cycle latency, registered output) among N_REQ requesters.
//   One request is granted per cycle; its operands are muxed straight to the
//   multiplier. A {valid,index} tag travels alongside the product through a
//   MULT_LAT-deep pipe so the result can be steered back to its owner. Any
//   disagreement between the tag valid and the multiplier's do_vld sets a
//   sticky error.
//
// Ports
//   clk    in   clock, rising edge
//   n_rst  in   asynchronous active-low reset
//   flush  in   synchronous clear of pointer and tag pipe, blocks grants
//   bus    slave modport of cmult_share_arb_if
//            req / d1_*_bus / d2_*_bus  requester operands (slot i packed
//                                       at [i*W +: W])
//            gnt                        one-hot grant (combinational)
//            m_di_vld, m_d1_*, m_d2_*   operands to multiplier
//            m_do_vld, m_do_re/im       product from multiplier
//            rsp_vld, rsp_re/im         one-hot result strobe + data
//   err    out  sticky tag/do_vld mismatch flag, cleared only by n_rst
// ---------------------------------------------------------------------------
module cmult_share_arb #(
    parameter int N_REQ    = 3,
    parameter int IDX_W    = 2,
    parameter int D1_SIZE  = 13,
    parameter int D2_SIZE  = 11,
    parameter int MULT_LAT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    cmult_share_arb_if.slave  bus,
    output logic              err
);

    // highest-priority index; only ever loaded with 0..N_REQ-1
    logic [IDX_W-1:0]    ptr;

    // arbitration results
    logic                gnt_en;
    logic [N_REQ-1:0]    gnt_c;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [IDX_W-1:0]    scan_idx;

    // tag pipe: stage MULT_LAT-1 lines up with m_do_vld / m_do_re
    logic [MULT_LAT-1:0] vld_pipe;
    logic [IDX_W-1:0]    idx_pipe [MULT_LAT];

    // remembers a flush for MULT_LAT cycles so products that were already
    // inside the multiplier do not trip the error check
    logic [MULT_LAT-1:0] flush_sh;
    logic                chk_mask;

    logic                tag_vld;
    logic [IDX_W-1:0]    tag_idx;

    // (a + b) mod N_REQ for a < N_REQ, 0 <= b < N_REQ
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input int               b);
        int s;
        s = int'(a) + b;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration: scan ptr, ptr+1, ... (mod N_REQ); first set req wins.
    // Grants are suppressed during reset and in the flush cycle.
    // ------------------------------------------------------------------
    assign gnt_en = n_rst & ~flush;

    always_comb begin
        gnt_c    = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            scan_idx = wrap_add(ptr, off);
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt_en && !gnt_any && scan_idx == IDX_W'(i) && bus.req[i]) begin
                    gnt_c[i] = 1'b1;
                    gnt_idx  = scan_idx;
                    gnt_any  = 1'b1;
                end
            end
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.m_di_vld = gnt_any;

    // ------------------------------------------------------------------
    // Operand mux: granted slot passes through, zeros when idle.
    // ------------------------------------------------------------------
    always_comb begin
        bus.m_d1_re = '0;
        bus.m_d1_im = '0;
        bus.m_d2_re = '0;
        bus.m_d2_im = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_c[i]) begin
                bus.m_d1_re = bus.d1_re_bus[i*D1_SIZE +: D1_SIZE];
                bus.m_d1_im = bus.d1_im_bus[i*D1_SIZE +: D1_SIZE];
                bus.m_d2_re = bus.d2_re_bus[i*D2_SIZE +: D2_SIZE];
                bus.m_d2_im = bus.d2_im_bus[i*D2_SIZE +: D2_SIZE];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer, tag pipe, flush shadow, sticky error
    // ------------------------------------------------------------------
    assign tag_vld  = vld_pipe[MULT_LAT-1];
    assign tag_idx  = idx_pipe[MULT_LAT-1];
    assign chk_mask = flush | (|flush_sh);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr      <= '0;
            vld_pipe <= '0;
            flush_sh <= '0;
            err      <= 1'b0;
            for (int k = 0; k < MULT_LAT; k++) idx_pipe[k] <= '0;
        end else begin
            flush_sh[0] <= flush;
            for (int k = 1; k < MULT_LAT; k++) flush_sh[k] <= flush_sh[k-1];

            idx_pipe[0] <= gnt_idx;
            for (int k = 1; k < MULT_LAT; k++) idx_pipe[k] <= idx_pipe[k-1];

            if (flush) begin
                ptr      <= '0;
                vld_pipe <= '0;
            end else begin
                if (gnt_any)
                    ptr <= (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
                vld_pipe[0] <= gnt_any;
                for (int k = 1; k < MULT_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
            end

            if (!chk_mask && (tag_vld != bus.m_do_vld))
                err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result steering: decode the aligned tag. The product arriving in the
    // flush cycle belongs to a dropped grant, so it is suppressed too.
    // ------------------------------------------------------------------
    always_comb begin
        bus.rsp_vld = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (n_rst && !flush && tag_vld && tag_idx == IDX_W'(i))
                bus.rsp_vld[i] = 1'b1;
        end
    end

    assign bus.rsp_re = bus.m_do_re;
    assign bus.rsp_im = bus.m_do_im;

endmodule

// File: tb/tb_cmult_share_arb.sv
module tb_cmult_share_arb;

    localparam int N   = 3;
    localparam int D1  = 13;
    localparam int D2  = 11;
    localparam int LAT = 2;

    logic clk;
    logic n_rst;
    logic flush;
    logic err;

    cmult_share_arb_if #(.N_REQ(N), .D1_SIZE(D1), .D2_SIZE(D2)) bus ();

    cmult_share_arb #(.N_REQ(N), .IDX_W(2), .D1_SIZE(D1), .D2_SIZE(D2), .MULT_LAT(LAT)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .flush (flush),
        .bus   (bus),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- requester operand slots ----------------
    logic signed [D1-1:0] d1r [N];
    logic signed [D1-1:0] d1i [N];
    logic signed [D2-1:0] d2r [N];
    logic signed [D2-1:0] d2i [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.d1_re_bus[i*D1 +: D1] = d1r[i];
            bus.d1_im_bus[i*D1 +: D1] = d1i[i];
            bus.d2_re_bus[i*D2 +: D2] = d2r[i];
            bus.d2_im_bus[i*D2 +: D2] = d2i[i];
        end
    end

    // ---------------- multiplier stand-in: 2 register stages ----------------
    logic            s1_vld, do_vld_r, force_vld;
    int              s1_re, s1_im;
    logic [D1:0]     do_re_r, do_im_r;

    function automatic int rnd(input int p);
        return (p + 512) >>> 10;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_vld <= 1'b0; s1_re <= 0; s1_im <= 0;
            do_vld_r <= 1'b0; do_re_r <= '0; do_im_r <= '0;
        end else begin
            s1_vld <= bus.m_di_vld;
            s1_re  <= rnd(int'($signed(bus.m_d1_re)) * int'($signed(bus.m_d2_re))
                        - int'($signed(bus.m_d1_im)) * int'($signed(bus.m_d2_im)));
            s1_im  <= rnd(int'($signed(bus.m_d1_re)) * int'($signed(bus.m_d2_im))
                        + int'($signed(bus.m_d1_im)) * int'($signed(bus.m_d2_re)));
            do_vld_r <= s1_vld;
            do_re_r  <= (D1+1)'(s1_re);
            do_im_r  <= (D1+1)'(s1_im);
        end
    end

    assign bus.m_do_vld = do_vld_r | force_vld;
    assign bus.m_do_re  = do_re_r;
    assign bus.m_do_im  = do_im_r;

    // ---------------- scoreboard ----------------
    typedef struct { int idx; int re; int im; int due; } exp_t;
    exp_t sb [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // monitor: the head entry must show up exactly on its due cycle,
    // and no strobe may appear without a queued expectation
    exp_t m_e;
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            m_e = sb.pop_front();
            chk("rsp_vld", int'(bus.rsp_vld), 1 << m_e.idx);
            chk("rsp_re", int'($signed(bus.rsp_re)), m_e.re);
            chk("rsp_im", int'($signed(bus.rsp_im)), m_e.im);
        end else if (bus.rsp_vld != '0) begin
            chk("stray_rsp_vld", int'(bus.rsp_vld), 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_slot(input int i, input int a, input int b, input int c, input int d);
        d1r[i] = D1'(a); d1i[i] = D1'(b); d2r[i] = D2'(c); d2i[i] = D2'(d);
    endtask

    // drive req for one cycle, check the grant, queue the expected result
    task automatic issue(input logic [N-1:0] r, input logic [N-1:0] eg,
                         input bit push, input int ere, input int eim);
        exp_t e;
        int   gi;
        bus.req = r;
        @(negedge clk);
        chk("gnt", int'(bus.gnt), int'(eg));
        chk("m_di_vld", int'(bus.m_di_vld), int'(|eg));
        if (eg != '0) begin
            gi = (eg == 3'b001) ? 0 : (eg == 3'b010) ? 1 : 2;
            chk("mux_d1_re", int'($signed(bus.m_d1_re)), int'(d1r[gi]));
            chk("mux_d2_im", int'($signed(bus.m_d2_im)), int'(d2i[gi]));
            if (push) begin
                e.idx = gi; e.re = ere; e.im = eim; e.due = cyc + LAT;
                sb.push_back(e);
            end
        end else begin
            chk("mux_idle_d1_re", int'(bus.m_d1_re), 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.req = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_rsp_vld", int'(bus.rsp_vld), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_rst = 1'b0; flush = 1'b0; force_vld = 1'b0; bus.req = '0;
        for (int i = 0; i < N; i++) set_slot(i, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // reset holds everything quiet even with all requests raised
        bus.req = 3'b111;
        @(negedge clk);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_di_vld", int'(bus.m_di_vld), 0);
        chk("rst_rsp_vld", int'(bus.rsp_vld), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk); #1;
        bus.req = '0;
        n_rst = 1'b1;

        // 1: single request, (100-50j)*(0.5) = 50-25j
        set_slot(0, 100, -50, 512, 0);
        issue(3'b001, 3'b001, 1, 50, -25);
        idle(4);

        // 2: all three requesting from a fresh reset -> 0,1,2,0,1,2
        do_reset();
        set_slot(0, 20, 4, 512, 0);      // -> (10, 2)
        set_slot(1, -40, 8, 512, 0);     // -> (-20, 4)
        set_slot(2, 60, -12, 0, 512);    // times 0.5j -> (6, 30)
        for (int c = 0; c < 6; c++) begin
            case (c % 3)
                0:       issue(3'b111, 3'b001, 1, 10, 2);
                1:       issue(3'b111, 3'b010, 1, -20, 4);
                default: issue(3'b111, 3'b100, 1, 6, 30);
            endcase
        end
        idle(4);

        // 3: back-to-back burst on slot 1, d2 = 1023/1024 rounds back to k
        for (int k = 1; k <= 8; k++) begin
            set_slot(1, k, 0, 1023, 0);
            issue(3'b010, 3'b010, 1, k, 0);
        end
        // slot 0 joins: ptr sits at 2, so grants alternate 0,1,0,1
        set_slot(0, 7, -3, 1023, 0);     // -> (7, -3)
        for (int c = 0; c < 4; c++) begin
            if (c % 2 == 0) issue(3'b011, 3'b001, 1, 7, -3);
            else            issue(3'b011, 3'b010, 1, 8, 0);
        end
        idle(4);

        // 4: two grants, then flush: both products dropped, ptr back to 0
        issue(3'b110, 3'b100, 0, 0, 0);
        issue(3'b110, 3'b010, 0, 0, 0);
        flush = 1'b1;
        issue(3'b111, 3'b000, 0, 0, 0);
        flush = 1'b0;
        issue(3'b111, 3'b001, 1, 7, -3);
        idle(4);
        chk("flush_err", int'(err), 0);

        // 5: spurious do_vld with no grant two cycles earlier
        force_vld = 1'b1;
        @(negedge clk);
        chk("err_before", int'(err), 0);
        @(posedge clk); #1;
        force_vld = 1'b0;
        @(negedge clk);
        chk("err_set", int'(err), 1);
        idle(3);
        chk("err_sticky", int'(err), 1);
        do_reset();

        // 6: reset while two results are in flight
        issue(3'b111, 3'b001, 0, 0, 0);
        issue(3'b111, 3'b010, 0, 0, 0);
        n_rst = 1'b0;
        #1;
        chk("midrst_gnt", int'(bus.gnt), 0);
        chk("midrst_rsp_vld", int'(bus.rsp_vld), 0);
        chk("midrst_err", int'(err), 0);
        @(posedge clk); @(posedge clk); #1;
        bus.req = '0;
        n_rst = 1'b1;
        idle(4);
        issue(3'b111, 3'b001, 1, 7, -3);
        idle(4);

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
